// File: rtl/surf4_spi_flash_seq.sv
// ---------------------------------------------------------------------------
// surf4_spi_flash_seq
//
// Purpose:
//   WISHBONE master for the simple SPI core (SPCR/SPSR/SPDR/SPER at adr 0..3).
//   Runs a complete flash read on its own: SPCR setup, chip-select on, opcode,
//   24-bit address (MSB first), N data bytes, chip-select off, done pulse.
//
// Optional feature macro: SURF4_SPI_SEQ_DUMMY_EN
//   When defined, DUMMY_BYTES bytes of 8'h00 are clocked with cs_o low
//   between the SPCR write and chip-select assertion, to move CCLK off the
//   configuration clock. A poll timeout there goes straight to DONE.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   start_i                1-cycle start pulse (ignored while busy_o)
//   cmd_i/addr_i/len_i     opcode, byte address, byte count (sampled on start)
//   busy_o, done_o, err_o  status: in progress, end pulse, sticky poll timeout
//   data_o, data_valid_o,  read data stream, valid/ready handshake
//   data_ready_i
//   cs_o                   flash select, active-high
//   spi_cyc_o/stb_o/we_o,  WISHBONE master side towards the SPI core
//   spi_adr_o, spi_dat_o,
//   spi_dat_i, spi_ack_i
//   dbg_state_o            current FSM state encoding
// ---------------------------------------------------------------------------
module surf4_spi_flash_seq #(
    parameter int         LEN_W       = 16,
    parameter logic [7:0] SPCR_INIT   = 8'h50,
    parameter int         POLL_LIMIT  = 1023,
    parameter int         DUMMY_BYTES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       cmd_i,
    input  logic [23:0]      addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [7:0]       data_o,
    output logic             data_valid_o,
    input  logic             data_ready_i,
    output logic             cs_o,
    output logic             spi_cyc_o,
    output logic             spi_stb_o,
    output logic             spi_we_o,
    output logic [1:0]       spi_adr_o,
    output logic [7:0]       spi_dat_o,
    input  logic [7:0]       spi_dat_i,
    input  logic             spi_ack_i,
    output logic [3:0]       dbg_state_o
);

    localparam int POLL_W = $clog2(POLL_LIMIT + 1);
    // Shared byte index for the ADDR phase (3 bytes) and the DUMMY phase.
    localparam int SUB_N  = (DUMMY_BYTES > 3) ? DUMMY_BYTES : 3;
    localparam int SUB_W  = $clog2(SUB_N + 1);

    localparam logic [1:0] ADR_SPCR = 2'd0;
    localparam logic [1:0] ADR_SPSR = 2'd1;
    localparam logic [1:0] ADR_SPDR = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
`ifdef SURF4_SPI_SEQ_DUMMY_EN
        S_DUMMY  = 4'd2,
`endif
        S_CS_ON  = 4'd3,
        S_CMD    = 4'd4,
        S_ADDR   = 4'd5,
        S_DATA   = 4'd6,
        S_CS_OFF = 4'd7,
        S_DONE   = 4'd8
    } state_e;

    // Byte transfer sub-phases: SPDR write, SPSR poll, SPDR read, and (DATA
    // only) holding the received byte until the consumer takes it.
    typedef enum logic [1:0] {
        PH_WR   = 2'd0,
        PH_POLL = 2'd1,
        PH_RD   = 2'd2,
        PH_HOLD = 2'd3
    } phase_e;

    state_e             state_q;
    phase_e             phase_q;
    logic [7:0]         cmd_q;
    logic [23:0]        addr_q;
    logic [LEN_W-1:0]   rem_q;
    logic [LEN_W-1:0]   rem_d;
    logic [POLL_W-1:0]  poll_cnt_q;
    logic [POLL_W-1:0]  poll_cnt_d;
    logic [SUB_W-1:0]   sub_cnt_q;
    logic [SUB_W-1:0]   sub_cnt_d;
    logic               busy_q, done_q, err_q, valid_q, cs_q;
    logic               spi_cyc_q, spi_stb_q, spi_we_q;
    logic [1:0]         spi_adr_q;
    logic [7:0]         spi_dat_q;
    logic [7:0]         data_q;
    logic [7:0]         tx_byte_d;
    logic               xfer_st;

    assign rem_d      = rem_q - LEN_W'(1);
    assign poll_cnt_d = poll_cnt_q + POLL_W'(1);
    assign sub_cnt_d  = sub_cnt_q + SUB_W'(1);

    // States that move bytes through SPDR.
    always_comb begin
        xfer_st = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
`ifdef SURF4_SPI_SEQ_DUMMY_EN
        if (state_q == S_DUMMY) xfer_st = 1'b1;
`endif
    end

    // Byte to shift out; DATA and DUMMY phases clock out zeros.
    always_comb begin
        tx_byte_d = 8'h00;
        if (state_q == S_CMD) begin
            tx_byte_d = cmd_q;
        end else if (state_q == S_ADDR) begin
            case (sub_cnt_q)
                SUB_W'(0): tx_byte_d = addr_q[23:16];
                SUB_W'(1): tx_byte_d = addr_q[15:8];
                default:   tx_byte_d = addr_q[7:0];
            endcase
        end
    end

    // Bus: cyc/stb rise together with adr/dat/we and stay stable until
    // spi_ack_i; the ack edge drops them, so one access is outstanding at most
    // and the next starts no earlier than one idle cycle later.
    // Data stream: data_o is presented with data_valid_o and held unchanged
    // until a clock edge sees data_valid_o & data_ready_i; valid falls after it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_WR;
            cmd_q      <= 8'h00;
            addr_q     <= 24'h0;
            rem_q      <= '0;
            poll_cnt_q <= '0;
            sub_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            cs_q       <= 1'b0;
            spi_cyc_q  <= 1'b0;
            spi_stb_q  <= 1'b0;
            spi_we_q   <= 1'b0;
            spi_adr_q  <= 2'd0;
            spi_dat_q  <= 8'h00;
            data_q     <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (xfer_st) begin
                case (phase_q)
                    PH_WR: begin
                        if (!spi_cyc_q) begin
                            spi_cyc_q <= 1'b1;
                            spi_stb_q <= 1'b1;
                            spi_we_q  <= 1'b1;
                            spi_adr_q <= ADR_SPDR;
                            spi_dat_q <= tx_byte_d;
                        end else if (spi_ack_i) begin
                            spi_cyc_q  <= 1'b0;
                            spi_stb_q  <= 1'b0;
                            spi_we_q   <= 1'b0;
                            poll_cnt_q <= '0;
                            phase_q    <= PH_POLL;
                        end
                    end
                    PH_POLL: begin
                        if (!spi_cyc_q) begin
                            spi_cyc_q <= 1'b1;
                            spi_stb_q <= 1'b1;
                            spi_we_q  <= 1'b0;
                            spi_adr_q <= ADR_SPSR;
                        end else if (spi_ack_i) begin
                            spi_cyc_q <= 1'b0;
                            spi_stb_q <= 1'b0;
                            if (!spi_dat_i[0]) begin
                                phase_q <= PH_RD;
                            end else if (poll_cnt_q == POLL_W'(POLL_LIMIT - 1)) begin
                                // Read FIFO never filled: abandon the transaction.
                                err_q   <= 1'b1;
                                phase_q <= PH_WR;
`ifdef SURF4_SPI_SEQ_DUMMY_EN
                                if (state_q == S_DUMMY) state_q <= S_DONE;
                                else                    state_q <= S_CS_OFF;
`else
                                state_q <= S_CS_OFF;
`endif
                            end else begin
                                poll_cnt_q <= poll_cnt_d;
                            end
                        end
                    end
                    PH_RD: begin
                        if (!spi_cyc_q) begin
                            spi_cyc_q <= 1'b1;
                            spi_stb_q <= 1'b1;
                            spi_we_q  <= 1'b0;
                            spi_adr_q <= ADR_SPDR;
                        end else if (spi_ack_i) begin
                            spi_cyc_q <= 1'b0;
                            spi_stb_q <= 1'b0;
                            phase_q   <= PH_WR;
                            case (state_q)
`ifdef SURF4_SPI_SEQ_DUMMY_EN
                                S_DUMMY: begin
                                    if (sub_cnt_q == SUB_W'(DUMMY_BYTES - 1)) state_q <= S_CS_ON;
                                    else                                      sub_cnt_q <= sub_cnt_d;
                                end
`endif
                                S_CMD: begin
                                    state_q   <= S_ADDR;
                                    sub_cnt_q <= '0;
                                end
                                S_ADDR: begin
                                    if (sub_cnt_q == SUB_W'(2)) begin
                                        state_q <= (rem_q == '0) ? S_CS_OFF : S_DATA;
                                    end else begin
                                        sub_cnt_q <= sub_cnt_d;
                                    end
                                end
                                S_DATA: begin
                                    data_q  <= spi_dat_i;
                                    valid_q <= 1'b1;
                                    phase_q <= PH_HOLD;
                                end
                                default: ;
                            endcase
                        end
                    end
                    PH_HOLD: begin
                        // No new SPDR write until the consumer takes the byte.
                        if (data_ready_i) begin
                            valid_q <= 1'b0;
                            rem_q   <= rem_d;
                            phase_q <= PH_WR;
                            if (rem_q == LEN_W'(1)) state_q <= S_CS_OFF;
                        end
                    end
                    default: phase_q <= PH_WR;
                endcase
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            cmd_q   <= cmd_i;
                            addr_q  <= addr_i;
                            rem_q   <= len_i;
                            busy_q  <= 1'b1;
                            err_q   <= 1'b0;
                            phase_q <= PH_WR;
                            state_q <= S_INIT;
                        end
                    end
                    S_INIT: begin
                        if (!spi_cyc_q) begin
                            spi_cyc_q <= 1'b1;
                            spi_stb_q <= 1'b1;
                            spi_we_q  <= 1'b1;
                            spi_adr_q <= ADR_SPCR;
                            spi_dat_q <= SPCR_INIT;
                        end else if (spi_ack_i) begin
                            spi_cyc_q <= 1'b0;
                            spi_stb_q <= 1'b0;
                            spi_we_q  <= 1'b0;
                            sub_cnt_q <= '0;
`ifdef SURF4_SPI_SEQ_DUMMY_EN
                            state_q   <= (DUMMY_BYTES > 0) ? S_DUMMY : S_CS_ON;
`else
                            state_q   <= S_CS_ON;
`endif
                        end
                    end
                    S_CS_ON: begin
                        cs_q    <= 1'b1;
                        phase_q <= PH_WR;
                        state_q <= S_CMD;
                    end
                    S_CS_OFF: begin
                        cs_q    <= 1'b0;
                        state_q <= S_DONE;
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign cs_o         = cs_q;
    assign spi_cyc_o    = spi_cyc_q;
    assign spi_stb_o    = spi_stb_q;
    assign spi_we_o     = spi_we_q;
    assign spi_adr_o    = spi_adr_q;
    assign spi_dat_o    = spi_dat_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_surf4_spi_flash_seq.sv
module tb_surf4_spi_flash_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [23:0] addr = 24'h0;
  logic [15:0] len = 16'h0;
  logic        ready = 1'b0;
  logic        busy, done, err, valid, cs;
  logic        spi_cyc, spi_stb, spi_we;
  logic [1:0]  spi_adr;
  logic [7:0]  spi_dat_o, data;
  logic [7:0]  spi_dat_i = 8'h00;
  logic        spi_ack_i = 1'b0;
  logic [3:0]  dbg_state;

`ifdef SURF4_SPI_SEQ_DUMMY_EN
  localparam int EXP_DUMMY = 2;
`else
  localparam int EXP_DUMMY = 0;
`endif

  surf4_spi_flash_seq #(
    .LEN_W(16), .SPCR_INIT(8'h50), .POLL_LIMIT(15), .DUMMY_BYTES(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cmd_i(cmd), .addr_i(addr),
    .len_i(len), .busy_o(busy), .done_o(done), .err_o(err), .data_o(data),
    .data_valid_o(valid), .data_ready_i(ready), .cs_o(cs),
    .spi_cyc_o(spi_cyc), .spi_stb_o(spi_stb), .spi_we_o(spi_we),
    .spi_adr_o(spi_adr), .spi_dat_o(spi_dat_o), .spi_dat_i(spi_dat_i),
    .spi_ack_i(spi_ack_i), .dbg_state_o(dbg_state)
  );

  // ---------------- simple-SPI core model + monitor ----------------
  logic       model_clr = 1'b0;
  logic       stuck_mode = 1'b0;
  logic       stuck_active = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  int         poll_left = 0;
  int         cs_hi_wr = 0, cs_low_wr = 0, cs_low_nz = 0, cs_low_after_hi = 0;
  int         spcr_wr = 0, stuck_polls = 0, done_cnt = 0, hs_cnt = 0;
  int         valid_cyc = 0, wr_while_valid = 0;
  logic [7:0] spcr_val = 8'h00;
  logic [7:0] spdr_q[$];
  logic [7:0] got_q[$];

  always @(posedge clk) begin
    spi_ack_i <= spi_cyc & spi_stb & ~spi_ack_i;
    if (model_clr) begin
      cs_hi_wr <= 0; cs_low_wr <= 0; cs_low_nz <= 0; cs_low_after_hi <= 0;
      spcr_wr <= 0; stuck_polls <= 0; done_cnt <= 0; hs_cnt <= 0;
      valid_cyc <= 0; wr_while_valid <= 0; poll_left <= 0; stuck_active <= 1'b0;
      spdr_q.delete();
      got_q.delete();
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (valid) valid_cyc <= valid_cyc + 1;
      if (valid & ready) begin
        got_q.push_back(data);
        hs_cnt <= hs_cnt + 1;
      end
      if (spi_cyc & spi_stb & ~spi_ack_i) begin
        spi_dat_i <= 8'h00;
        if (spi_we) begin
          if (spi_adr == 2'd0) begin
            spcr_wr  <= spcr_wr + 1;
            spcr_val <= spi_dat_o;
          end else if (spi_adr == 2'd2) begin
            if (valid) wr_while_valid <= wr_while_valid + 1;
            poll_left <= 2;
            if (cs) begin
              spdr_q.push_back(spi_dat_o);
              stuck_active <= stuck_mode && (cs_hi_wr == 2);
              rx_byte <= 8'(32'h9C + cs_hi_wr);
              cs_hi_wr <= cs_hi_wr + 1;
            end else begin
              cs_low_wr <= cs_low_wr + 1;
              if (spi_dat_o != 8'h00) cs_low_nz <= cs_low_nz + 1;
              if (cs_hi_wr != 0) cs_low_after_hi <= cs_low_after_hi + 1;
              stuck_active <= 1'b0;
              rx_byte <= 8'h00;
            end
          end
        end else if (spi_adr == 2'd1) begin
          if (stuck_active) begin
            spi_dat_i <= 8'h01;
            stuck_polls <= stuck_polls + 1;
          end else begin
            spi_dat_i <= {7'b0, (poll_left != 0)};
            if (poll_left != 0) poll_left <= poll_left - 1;
          end
        end else if (spi_adr == 2'd2) begin
          spi_dat_i <= rx_byte;
        end
      end
    end
  end

  // ---------------- scoreboard / checks ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_spdr(input string tag);
    chk({tag, " spdr_count"}, spdr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < spdr_q.size(); i++)
      chk($sformatf("%s spdr[%0d]", tag, i), spdr_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic chk_data(input string tag);
    chk({tag, " data_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s data[%0d]", tag, i), got_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic clr_model();
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] c, input logic [23:0] a, input logic [15:0] l);
    cmd = c; addr = a; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (done_cnt == 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({tag, " done_seen"}, (done_cnt != 0), 1);
    repeat (4) @(negedge clk);
    chk({tag, " done_once"}, done_cnt, 1);
    chk({tag, " busy_low"}, busy, 1'b0);
    chk({tag, " cs_low"}, cs, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] held;
    int stall_bad;
    int i;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);      chk("rst done", done, 0);
    chk("rst err", err, 0);        chk("rst valid", valid, 0);
    chk("rst cs", cs, 0);          chk("rst cyc", spi_cyc, 0);
    chk("rst stb", spi_stb, 0);    chk("rst we", spi_we, 0);
    chk("rst data", data, 0);      chk("rst adr", spi_adr, 0);
    chk("rst dat_o", spi_dat_o, 0);
    rst = 1'b0;
    @(negedge clk);
    clr_model();

    // 1: cmd 03, addr 123456, 4 bytes, consumer always ready
    ready = 1'b1;
    do_start(8'h03, 24'h123456, 16'd4);
    chk("t1 busy_rise", busy, 1'b1);
    wait_done("t1", 3000);
    chk("t1 spcr_writes", spcr_wr, 1);
    chk("t1 spcr_value", spcr_val, 8'h50);
    exp_q = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00};
    chk_spdr("t1");
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    chk_data("t1");
    chk("t1 err", err, 1'b0);
    // 6: dummy bytes with cs low only when the feature is built in
    chk("t6 cs_low_writes", cs_low_wr, EXP_DUMMY);
    chk("t6 cs_low_nonzero", cs_low_nz, 0);
    chk("t6 dummy_after_cs", cs_low_after_hi, 0);
    clr_model();

    // 2: zero-length read
    do_start(8'h0B, 24'h000100, 16'd0);
    wait_done("t2", 2000);
    exp_q = '{8'h0B, 8'h00, 8'h01, 8'h00};
    chk_spdr("t2");
    chk("t2 valid_never", valid_cyc, 0);
    clr_model();

    // 3: consumer stalls 20 cycles per byte; start while busy is ignored
    ready = 1'b0;
    stall_bad = 0;
    do_start(8'h03, 24'hABCDEF, 16'd3);
    for (int b = 0; b < 3; b++) begin
      i = 0;
      while (!valid && i < 800) begin
        @(negedge clk);
        i++;
      end
      chk($sformatf("t3 valid_seen[%0d]", b), valid, 1'b1);
      held = data;
      chk($sformatf("t3 byte[%0d]", b), held, 8'(8'hA0 + b));
      if (b == 1) do_start(8'hFF, 24'hFFFFFF, 16'd9);
      repeat (20) begin
        @(negedge clk);
        if (data !== held || valid !== 1'b1) stall_bad++;
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
    end
    wait_done("t3", 2000);
    chk("t3 stall_stable", stall_bad, 0);
    chk("t3 wr_while_valid", wr_while_valid, 0);
    chk("t3 handshakes", hs_cnt, 3);
    exp_q = '{8'h03, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00};
    chk_spdr("t3");
    clr_model();

    // 4: RFEMPTY stuck after 2nd address byte -> timeout
    ready = 1'b1;
    stuck_mode = 1'b1;
    do_start(8'h03, 24'h123456, 16'd4);
    wait_done("t4", 3000);
    chk("t4 polls", stuck_polls, 15);
    chk("t4 err_set", err, 1'b1);
    chk("t4 spdr_count", spdr_q.size(), 3);
    chk("t4 no_data", valid_cyc, 0);
    stuck_mode = 1'b0;
    clr_model();
    chk("t4 err_sticky", err, 1'b1);
    do_start(8'h03, 24'h000000, 16'd1);
    chk("t4 err_cleared", err, 1'b0);
    wait_done("t4b", 2000);
    chk("t4b err", err, 1'b0);
    exp_q = '{8'hA0};
    chk_data("t4b");
    clr_model();

    // 5: reset in the middle of a DATA bus cycle
    do_start(8'h03, 24'h123456, 16'd4);
    i = 0;
    while (!(cs_hi_wr >= 6 && spi_cyc) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("t5 reached_data", (cs_hi_wr >= 6 && spi_cyc), 1);
    rst = 1'b1;
    #1;
    chk("t5 cs_drop", cs, 1'b0);
    chk("t5 cyc_drop", spi_cyc, 1'b0);
    chk("t5 busy_drop", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clr_model();
    do_start(8'h03, 24'h123456, 16'd2);
    wait_done("t5b", 2000);
    exp_q = '{8'hA0, 8'hA1};
    chk_data("t5b");
    chk("t5b err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
